// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side decode inputs, forwarding sources, pipeline control
// and the registered ALU-facing outputs.
interface id_ex_stage_if;
  logic        id_valid;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm;
  logic [31:0] id_rs_val, id_rt_val;
  logic        exmem_wen;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_wen;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall_in, flush_in;
  logic        hazard_stall;
  logic        ex_valid;
  logic [31:0] ex_op1, ex_op2;
  logic [4:0]  ex_operation, ex_shamt, ex_dest;
  logic        ex_regwrite, ex_illegal;

  modport master (
    output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
           id_rs_val, id_rt_val, exmem_wen, exmem_rd, exmem_result,
           memwb_wen, memwb_rd, memwb_result, stall_in, flush_in,
    input  hazard_stall, ex_valid, ex_op1, ex_op2, ex_operation, ex_shamt,
           ex_dest, ex_regwrite, ex_illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
           id_rs_val, id_rt_val, exmem_wen, exmem_rd, exmem_result,
           memwb_wen, memwb_rd, memwb_result, stall_in, flush_in,
    output hazard_stall, ex_valid, ex_op1, ex_op2, ex_operation, ex_shamt,
           ex_dest, ex_regwrite, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX stage: decode into ALU operation/operands with EX/MEM and MEM/WB
// forwarding, load-use style bubble on a dependency with the EX instruction.
module id_ex_stage (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        regwrite;
    logic        illegal;
  } ex_t;

  ex_t         dec, ex_d, ex_q;
  logic        ex_valid_d, ex_valid_q;
  logic        uses_rs, uses_rt, wr, hazard;
  logic [31:0] rs_fwd, rt_fwd, imm_s, imm_z;

  always_comb begin
    rs_fwd = bus.id_rs_val;
    if (bus.id_rs == 5'd0) rs_fwd = '0;
    else if (bus.exmem_wen && bus.exmem_rd == bus.id_rs) rs_fwd = bus.exmem_result;
    else if (bus.memwb_wen && bus.memwb_rd == bus.id_rs) rs_fwd = bus.memwb_result;
    rt_fwd = bus.id_rt_val;
    if (bus.id_rt == 5'd0) rt_fwd = '0;
    else if (bus.exmem_wen && bus.exmem_rd == bus.id_rt) rt_fwd = bus.exmem_result;
    else if (bus.memwb_wen && bus.memwb_rd == bus.id_rt) rt_fwd = bus.memwb_result;
  end

  assign imm_s = {{16{bus.id_imm[15]}}, bus.id_imm};
  assign imm_z = {16'h0, bus.id_imm};

  always_comb begin
    dec     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    wr      = 1'b0;
    case (bus.id_opcode)
      6'h00: begin
        dec.dest = bus.id_rd;
        case (bus.id_funct)
          6'h20, 6'h21, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B: begin
            dec.op1 = rs_fwd; dec.op2 = rt_fwd;
            uses_rs = 1'b1; uses_rt = 1'b1; wr = 1'b1;
            case (bus.id_funct)
              6'h24:   dec.op = 5'd4;
              6'h25:   dec.op = 5'd2;
              6'h27:   dec.op = 5'hA;
              6'h2A:   dec.op = 5'd8;
              6'h2B:   dec.op = 5'd9;
              default: dec.op = 5'd3;
            endcase
          end
          // ALU subtracts Op2-Op1, so rs/rt are swapped to get rs-rt
          6'h22, 6'h23: begin
            dec.op = 5'd5; dec.op1 = rt_fwd; dec.op2 = rs_fwd;
            uses_rs = 1'b1; uses_rt = 1'b1; wr = 1'b1;
          end
          6'h00, 6'h02: begin
            dec.op = bus.id_funct[1] ? 5'd7 : 5'd6;
            dec.op2 = rt_fwd; dec.shamt = bus.id_shamt;
            uses_rt = 1'b1; wr = 1'b1;
          end
          6'h08: begin
            dec.op = 5'hB; dec.op2 = rs_fwd; uses_rs = 1'b1;
          end
          default: begin
            dec.illegal = 1'b1; dec.dest = '0;
          end
        endcase
      end
      6'h08, 6'h09, 6'h23: begin
        dec.op = 5'd3; dec.op1 = rs_fwd; dec.op2 = imm_s; uses_rs = 1'b1; wr = 1'b1;
      end
      6'h0A, 6'h0B: begin
        dec.op = bus.id_opcode[0] ? 5'd9 : 5'd8;
        dec.op1 = rs_fwd; dec.op2 = imm_s; uses_rs = 1'b1; wr = 1'b1;
      end
      6'h0C, 6'h0D: begin
        dec.op = bus.id_opcode[0] ? 5'd2 : 5'd4;
        dec.op1 = rs_fwd; dec.op2 = imm_z; uses_rs = 1'b1; wr = 1'b1;
      end
      6'h0F: begin
        dec.op = 5'd1; dec.op2 = imm_z; wr = 1'b1;
      end
      6'h2B: begin
        dec.op = 5'd3; dec.op1 = rs_fwd; dec.op2 = imm_s; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      6'h04, 6'h05: begin
        dec.op = 5'd5; dec.op1 = rt_fwd; dec.op2 = rs_fwd; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (!dec.illegal && bus.id_opcode != 6'h00) dec.dest = bus.id_rt;
    dec.regwrite = wr && (dec.dest != 5'd0);
  end

  assign hazard = bus.id_valid && ex_valid_q && ex_q.regwrite && (ex_q.dest != 5'd0) &&
                  ((uses_rs && bus.id_rs == ex_q.dest) || (uses_rt && bus.id_rt == ex_q.dest));

  // Bubbles and flushes clear the control fields only; operand fields are don't-care
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush_in || (!bus.stall_in && hazard)) begin
      ex_valid_d = 1'b0; ex_d.regwrite = 1'b0; ex_d.op = '0; ex_d.illegal = 1'b0;
    end else if (!bus.stall_in) begin
      ex_d       = dec;
      ex_valid_d = bus.id_valid;
      if (!bus.id_valid) begin
        ex_d.regwrite = 1'b0; ex_d.op = '0; ex_d.illegal = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_op1       = ex_q.op1;
  assign bus.ex_op2       = ex_q.op2;
  assign bus.ex_operation = ex_q.op;
  assign bus.ex_shamt     = ex_q.shamt;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode/forwarding vector table through a scoreboard,
// plus hazard, stall/flush and asynchronous reset sequences.
module tb_id_ex_stage;
  logic clk, rst;
  id_ex_stage_if bus();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] rsv, rtv;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic [4:0]  e_op;
    logic [31:0] e_op1, e_op2;
    logic [4:0]  e_sh, e_dst;
    logic        e_rw, e_ill;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [31:0] op1, op2;
    logic [4:0]  sh, dst;
    logic        rw, ill;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[17];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(e.valid));
    chk({tag, ".op"}, 32'(bus.ex_operation), 32'(e.op));
    chk({tag, ".op1"}, bus.ex_op1, e.op1);
    chk({tag, ".op2"}, bus.ex_op2, e.op2);
    chk({tag, ".shamt"}, 32'(bus.ex_shamt), 32'(e.sh));
    chk({tag, ".dest"}, 32'(bus.ex_dest), 32'(e.dst));
    chk({tag, ".regwrite"}, 32'(bus.ex_regwrite), 32'(e.rw));
    chk({tag, ".illegal"}, 32'(bus.ex_illegal), 32'(e.ill));
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid = 1'b1; bus.id_opcode = v.opc; bus.id_funct = v.fn;
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rd = v.rd; bus.id_shamt = v.sh;
    bus.id_imm = v.imm; bus.id_rs_val = v.rsv; bus.id_rt_val = v.rtv;
    bus.exmem_wen = v.xw; bus.exmem_rd = v.xrd; bus.exmem_result = v.xres;
    bus.memwb_wen = v.mw; bus.memwb_rd = v.mrd; bus.memwb_result = v.mres;
  endtask

  // R-type helper: opcode 0, forwarding off
  task automatic drive_r(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv);
    vec_t v;
    v = '{6'h00, fn, rs, rt, rd, 5'd0, 16'h0, rsv, rtv, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0};
    drive(v);
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.exmem_wen = 1'b0; bus.memwb_wen = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    bus.stall_in = 1'b0; bus.flush_in = 1'b0;
    drive_r(6'h20, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    idle();

    //        opc    fn     rs    rt    rd     sh    imm       rsv         rtv        xw   xrd   xres        mw   mrd   mres        op     op1         op2           sh    dst    rw    ill
    vecs[0]  = '{6'h08, 6'h00, 5'd1, 5'd7, 5'd0,  5'd0, 16'hFFFF, 32'd5,      32'd0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd3,  32'd5,      32'hFFFFFFFF, 5'd0, 5'd7,  1'b1, 1'b0};
    vecs[1]  = '{6'h00, 6'h22, 5'd2, 5'd3, 5'd9,  5'd0, 16'h0000, 32'd10,     32'd4,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd5,  32'd4,      32'd10,       5'd0, 5'd9,  1'b1, 1'b0};
    vecs[2]  = '{6'h0F, 6'h00, 5'd1, 5'd5, 5'd0,  5'd0, 16'h1234, 32'd5,      32'd0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd1,  32'd0,      32'h00001234, 5'd0, 5'd5,  1'b1, 1'b0};
    vecs[3]  = '{6'h0D, 6'h00, 5'd1, 5'd6, 5'd0,  5'd0, 16'h8000, 32'd5,      32'd0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd2,  32'd5,      32'h00008000, 5'd0, 5'd6,  1'b1, 1'b0};
    vecs[4]  = '{6'h00, 6'h20, 5'd2, 5'd3, 5'd8,  5'd0, 16'h0000, 32'd1,      32'd4,     1'b1, 5'd2, 32'hAA,     1'b1, 5'd2, 32'hBB,     5'd3,  32'hAA,     32'd4,        5'd0, 5'd8,  1'b1, 1'b0};
    vecs[5]  = '{6'h00, 6'h20, 5'd0, 5'd3, 5'd8,  5'd0, 16'h0000, 32'h77,     32'd4,     1'b1, 5'd0, 32'hAA,     1'b1, 5'd0, 32'hBB,     5'd3,  32'd0,      32'd4,        5'd0, 5'd8,  1'b1, 1'b0};
    vecs[6]  = '{6'h00, 6'h00, 5'd1, 5'd3, 5'd1,  5'd4, 16'h0000, 32'd5,      32'hF,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd6,  32'd0,      32'hF,        5'd4, 5'd1,  1'b1, 1'b0};
    vecs[7]  = '{6'h00, 6'h08, 5'd5, 5'd0, 5'd31, 5'd0, 16'h0000, 32'h400,    32'd0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'hB,  32'd0,      32'h400,      5'd0, 5'd31, 1'b0, 1'b0};
    vecs[8]  = '{6'h3F, 6'h00, 5'd1, 5'd2, 5'd3,  5'd0, 16'h0001, 32'd5,      32'd9,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd0,  32'd0,      32'd0,        5'd0, 5'd0,  1'b0, 1'b1};
    vecs[9]  = '{6'h04, 6'h00, 5'd1, 5'd2, 5'd0,  5'd0, 16'h0010, 32'd5,      32'd9,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd5,  32'd9,      32'd5,        5'd0, 5'd2,  1'b0, 1'b0};
    vecs[10] = '{6'h00, 6'h20, 5'd4, 5'd3, 5'd8,  5'd0, 16'h0000, 32'd1,      32'd4,     1'b0, 5'd0, 32'h0,      1'b1, 5'd4, 32'hCC,     5'd3,  32'hCC,     32'd4,        5'd0, 5'd8,  1'b1, 1'b0};
    vecs[11] = '{6'h00, 6'h20, 5'd1, 5'd2, 5'd0,  5'd0, 16'h0000, 32'd5,      32'd9,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd3,  32'd5,      32'd9,        5'd0, 5'd0,  1'b0, 1'b0};
    vecs[12] = '{6'h2B, 6'h00, 5'd1, 5'd2, 5'd0,  5'd0, 16'hFFFC, 32'd5,      32'd9,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd3,  32'd5,      32'hFFFFFFFC, 5'd0, 5'd2,  1'b0, 1'b0};
    vecs[13] = '{6'h0C, 6'h00, 5'd1, 5'd3, 5'd0,  5'd0, 16'hF0F0, 32'd5,      32'd0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd4,  32'd5,      32'h0000F0F0, 5'd0, 5'd3,  1'b1, 1'b0};
    vecs[14] = '{6'h0B, 6'h00, 5'd1, 5'd3, 5'd0,  5'd0, 16'h8000, 32'd5,      32'd0,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd9,  32'd5,      32'hFFFF8000, 5'd0, 5'd3,  1'b1, 1'b0};
    vecs[15] = '{6'h00, 6'h27, 5'd1, 5'd2, 5'd10, 5'd0, 16'h0000, 32'd5,      32'd9,     1'b1, 5'd2, 32'h33,     1'b0, 5'd0, 32'h0,      5'hA,  32'd5,      32'h33,       5'd0, 5'd10, 1'b1, 1'b0};
    vecs[16] = '{6'h00, 6'h03, 5'd1, 5'd2, 5'd3,  5'd0, 16'h0000, 32'd5,      32'd9,     1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      5'd0,  32'd0,      32'd0,        5'd0, 5'd0,  1'b0, 1'b1};

    #3;
    e = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0};
    chk_out("reset", e);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back('{1'b1, vecs[i].e_op, vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_sh,
                     vecs[i].e_dst, vecs[i].e_rw, vecs[i].e_ill});
      #1 chk($sformatf("v%0d.hazard", i), 32'(bus.hazard_stall), 32'd0);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk_out($sformatf("v%0d", i), e);
      @(negedge clk); idle();
      @(posedge clk); #1;
      chk($sformatf("v%0d.idle_valid", i), 32'(bus.ex_valid), 32'd0);
      chk($sformatf("v%0d.idle_rw", i), 32'(bus.ex_regwrite), 32'd0);
    end

    // dependency on EX: bubble, then capture with the forwarded value
    @(negedge clk); drive_r(6'h20, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2);
    @(negedge clk); drive_r(6'h25, 5'd4, 5'd3, 5'd5, 32'd0, 32'h10);
    #1 chk("haz.stall", 32'(bus.hazard_stall), 32'd1);
    @(posedge clk); #1;
    chk("haz.bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("haz.bubble_op", 32'(bus.ex_operation), 32'd0);
    chk("haz.released", 32'(bus.hazard_stall), 32'd0);
    @(negedge clk); bus.exmem_wen = 1'b1; bus.exmem_rd = 5'd4; bus.exmem_result = 32'h99;
    @(posedge clk); #1;
    e = '{1'b1, 5'd2, 32'h99, 32'h10, 5'd0, 5'd5, 1'b1, 1'b0};
    chk_out("haz.capture", e);

    // downstream stall holds, flush overrides stall
    @(negedge clk); bus.stall_in = 1'b1; drive_r(6'h20, 5'd1, 5'd1, 5'd6, 32'd7, 32'd7);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk_out($sformatf("stall%0d", c), e);
    end
    @(negedge clk); bus.flush_in = 1'b1;
    @(posedge clk); #1;
    chk("flush.valid", 32'(bus.ex_valid), 32'd0);
    chk("flush.op", 32'(bus.ex_operation), 32'd0);
    chk("flush.rw", 32'(bus.ex_regwrite), 32'd0);
    @(negedge clk); bus.flush_in = 1'b0; bus.stall_in = 1'b0;

    // destination r0 never stalls
    drive_r(6'h20, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2);
    @(negedge clk); drive_r(6'h20, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0);
    #1 chk("dest0.hazard", 32'(bus.hazard_stall), 32'd0);

    // async reset while stalled
    @(negedge clk); drive_r(6'h21, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4);
    @(posedge clk); #1 chk("pre_rst.valid", 32'(bus.ex_valid), 32'd1);
    @(negedge clk); bus.stall_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    e = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0};
    chk_out("rst_mid", e);
    @(negedge clk); rst = 1'b0; bus.stall_in = 1'b0; idle();
    @(posedge clk); #1 chk("post_rst.valid", 32'(bus.ex_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the EX-stage ALU.
- Decodes opcode/funct into the ALU's 5-bit operation code and selects and extends operands, with forwarding from EX/MEM and MEM/WB.
- Detects a dependency on the instruction currently in EX and inserts a bubble for it.
- Registers everything the ALU consumes: Op1, Op2, operation, shamt.

Parameters:
- none.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  6  instr[31:26]
- id_funct  in  6  instr[5:0]
- id_rs  in  5  source register address
- id_rt  in  5  source register address
- id_rd  in  5  destination register address
- id_shamt  in  5  shift amount
- id_imm  in  16  instr[15:0]
- id_rs_val  in  32  register-file read value for rs
- id_rt_val  in  32  register-file read value for rt
- exmem_wen  in  1  EX/MEM write-enable
- exmem_rd  in  5  EX/MEM destination register
- exmem_result  in  32  EX/MEM result
- memwb_wen  in  1  MEM/WB write-enable
- memwb_rd  in  5  MEM/WB destination register
- memwb_result  in  32  MEM/WB result
- stall_in  in  1  downstream hold
- flush_in  in  1  squash the stage
- hazard_stall  out  1  combinational; ID/IF must hold
- ex_valid  out  1  registered; stage holds a valid instruction
- ex_op1  out  32  registered; ALU Op1
- ex_op2  out  32  registered; ALU Op2
- ex_operation  out  5  registered; ALU operation code
- ex_shamt  out  5  registered; ALU shift amount
- ex_dest  out  5  registered; destination register
- ex_regwrite  out  1  registered; destination is written
- ex_illegal  out  1  registered; unknown opcode/funct

Behaviour:
- Reset: asynchronous, active-high. All registered outputs go to 0; operation 0 is the ALU no-op.
- Latency: 1 cycle from ID capture to ex_* outputs.

Decode (operation; Op1/Op2):
- R-type, opcode 0x00:
  - add/addu 0x20/0x21 -> 3; rs/rt.
  - sub/subu 0x22/0x23 -> 5; Op1=rt, Op2=rs. Swapped because the ALU computes Op2-Op1, so the result is rs-rt.
  - and 0x24 -> 4; or 0x25 -> 2; nor 0x27 -> 0xA; slt 0x2A -> 8; sltu 0x2B -> 9. All rs/rt.
  - sll 0x00 -> 6; srl 0x02 -> 7. Op2=rt, shamt=id_shamt.
  - jr 0x08 -> 0xB; Op2=rs; no write.
  - dest=rd for all R-type.
- I-type, dest=rt:
  - addi/addiu 0x08/0x09 -> 3, sign-extended imm.
  - slti 0x0A -> 8, sign-extended. sltiu 0x0B -> 9, sign-extended.
  - andi 0x0C -> 4, zero-extended. ori 0x0D -> 2, zero-extended.
  - lui 0x0F -> 1, Op2={16'h0, imm}.
  - lw 0x23 -> 3, sign-extended.
  - sw 0x2B -> 3, sign-extended; no write.
  - beq/bne 0x04/0x05 -> 5; Op1=rt, Op2=rs; no write.
- ex_shamt = 0 except sll/srl.
- Anything else: operation 0, regwrite 0, ex_illegal 1; ex_valid still follows id_valid.
- ex_regwrite is forced 0 when dest is 0.

Forwarding (per used source):
- Priority: EX/MEM (wen && rd==src && src!=0), then MEM/WB (same condition), then register-file value.
- Applied before operand swap and immediate select.
- Register 0 always reads 0.

Hazard:
- hazard_stall = id_valid && ex_valid && ex_regwrite && ex_dest!=0 && ((uses_rs && id_rs==ex_dest) || (uses_rt && id_rt==ex_dest)).
- uses_rt is false for I-type ALU ops, lui and lw; true for sw/beq/bne.
- lui uses neither source; jr uses rs only.

Update priority, per clock edge:
1. flush_in: ex_valid=0, ex_regwrite=0, operation=0. Wins over everything including stall_in.
2. stall_in: hold all ex_* registers. hazard_stall is still driven.
3. hazard_stall: bubble (ex_valid=0, ex_regwrite=0, operation=0); the ID instruction is re-presented next cycle.
4. otherwise: capture decode; ex_valid=id_valid. If !id_valid, ex_regwrite=0 and operation=0.

Boundary conditions:
- Reset mid-stall returns everything to 0.
- Simultaneous EX/MEM and MEM/WB match to the same register: EX/MEM wins.
- Dest 0 never triggers a hazard.

Test Plan:
- Reset, then addi rs=1 (rf=5), imm=0xFFFF -> next cycle op=3, Op1=5, Op2=0xFFFFFFFF, dest=rt, regwrite=1.
- sub rs=2 (10), rt=3 (4) -> op=5, Op1=4, Op2=10; lui imm=0x1234 -> op=1, Op2=0x00001234; ori imm=0x8000 -> Op2=0x00008000.
- EX/MEM wen, rd=2, result=0xAA, and MEM/WB wen, rd=2, result=0xBB; add rs=2 -> Op1=0xAA. Same with rd=0 and rs=0 -> Op1=0.
- EX holds add to r4 (regwrite=1); ID holds or reading r4 -> hazard_stall=1, next ex_valid=0; following cycle or captured with forwarded value.
- stall_in=1 for 2 cycles -> ex_* unchanged; flush_in together with stall_in -> ex_valid=0, op=0 next edge.
- opcode 0x3F -> ex_illegal=1, op=0, regwrite=0; rst asserted mid-stream -> all outputs 0 immediately, without a clock edge.
